// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt
// Multi-way speculative register rename map with a circular bank of map
// checkpoints. Renames up to WIDTH instructions per cycle with intra-group
// bypass, snapshots the next-state map on branch dispatch and restores any
// live checkpoint in a single cycle on mispredict.
module rename_map_ckpt #(
    parameter int ARCH  = 32,
    parameter int PHYS  = 64,
    parameter int AW    = 5,
    parameter int PW    = 6,
    parameter int WIDTH = 2,
    parameter int NCKPT = 4,
    parameter int CW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    ren_vld,
    input  logic [WIDTH-1:0]    ren_we,
    input  logic [WIDTH*AW-1:0] rs1,
    input  logic [WIDTH*AW-1:0] rs2,
    input  logic [WIDTH*AW-1:0] rd,
    input  logic [WIDTH*PW-1:0] prd_new,
    output logic [WIDTH*PW-1:0] prs1,
    output logic [WIDTH*PW-1:0] prs2,
    output logic [WIDTH*PW-1:0] prd_old,
    input  logic                ckpt_req,
    output logic                ckpt_gnt,
    output logic [CW-1:0]       ckpt_id,
    input  logic                ckpt_free,
    input  logic                restore_en,
    input  logic [CW-1:0]       restore_id,
    output logic [CW:0]         ckpt_cnt,
    output logic                ckpt_full,
    output logic                restore_err
);

    localparam logic [CW:0] FULL_CNT = (CW+1)'(NCKPT);

    logic [PW-1:0] map_q   [ARCH];
    logic [PW-1:0] map_nxt [ARCH];
    logic [PW-1:0] snap_q  [NCKPT][ARCH];

    logic [CW-1:0] head_q;
    logic [CW-1:0] tail_q;
    logic [CW-1:0] rdist;
    logic [CW:0]   cnt_q;
    logic [CW:0]   cnt_nxt;
    logic          full_q;
    logic          err_q;
    logic          live;
    logic          gnt;
    logic          free_ok;

    // Source and old-destination lookup: map read, overridden by the youngest older writer in the group
    always_comb begin
        prs1    = '0;
        prs2    = '0;
        prd_old = '0;
        for (int j = 0; j < WIDTH; j++) begin
            prs1[j*PW +: PW]    = map_q[rs1[j*AW +: AW]];
            prs2[j*PW +: PW]    = map_q[rs2[j*AW +: AW]];
            prd_old[j*PW +: PW] = map_q[rd[j*AW +: AW]];
            for (int k = 0; k < j; k++) begin
                if (ren_vld[k] && ren_we[k]) begin
                    if (rd[k*AW +: AW] == rs1[j*AW +: AW])
                        prs1[j*PW +: PW] = prd_new[k*PW +: PW];
                    if (rd[k*AW +: AW] == rs2[j*AW +: AW])
                        prs2[j*PW +: PW] = prd_new[k*PW +: PW];
                    if (rd[k*AW +: AW] == rd[j*AW +: AW])
                        prd_old[j*PW +: PW] = prd_new[k*PW +: PW];
                end
            end
        end
    end

    // Map after this group's writes; later ways overwrite earlier ones on a shared rd
    always_comb begin
        map_nxt = map_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (ren_vld[i] && ren_we[i])
                map_nxt[rd[i*AW +: AW]] = prd_new[i*PW +: PW];
        end
    end

    // Checkpoint bookkeeping: liveness of the restore target, grant, free and the next count
    always_comb begin
        rdist   = restore_id - head_q;
        live    = ({1'b0, rdist} < cnt_q);
        gnt     = ckpt_req && !restore_en && (cnt_q < FULL_CNT);
        free_ok = ckpt_free && !restore_en && (cnt_q != '0);
        cnt_nxt = cnt_q;
        if (restore_en) begin
            if (live)
                cnt_nxt = {1'b0, rdist};
        end else begin
            cnt_nxt = cnt_q + (CW+1)'(gnt) - (CW+1)'(free_ok);
        end
    end

    // Map, pointers and status registers; a restore overrides any rename or free this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH; i++)
                map_q[i] <= PW'(i % PHYS);
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (restore_en) begin
                if (live) begin
                    map_q  <= snap_q[restore_id];
                    tail_q <= restore_id;
                end
            end else begin
                map_q <= map_nxt;
                if (gnt)
                    tail_q <= tail_q + 1'b1;
                if (free_ok)
                    head_q <= head_q + 1'b1;
            end
            cnt_q  <= cnt_nxt;
            full_q <= (cnt_nxt == FULL_CNT);
            err_q  <= restore_en && !live;
        end
    end

    // Snapshot storage holds the post-update map; contents need no reset
    always_ff @(posedge clk) begin
        if (gnt)
            snap_q[tail_q] <= map_nxt;
    end

    assign ckpt_gnt    = gnt;
    assign ckpt_id     = tail_q;
    assign ckpt_cnt    = cnt_q;
    assign ckpt_full   = full_q;
    assign restore_err = err_q;

endmodule

// File: tb/tb_rename_map_ckpt.sv
// tb_rename_map_ckpt
// Directed vector table, hand-written multi-cycle sequences and a randomized
// run compared against a queue-based behavioural model of the rename map.
module tb_rename_map_ckpt;

    localparam int AW = 5;
    localparam int PW = 6;
    localparam int WIDTH = 2;
    localparam int CW = 2;

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    ren_vld;
    logic [WIDTH-1:0]    ren_we;
    logic [WIDTH*AW-1:0] rs1;
    logic [WIDTH*AW-1:0] rs2;
    logic [WIDTH*AW-1:0] rd;
    logic [WIDTH*PW-1:0] prd_new;
    logic [WIDTH*PW-1:0] prs1;
    logic [WIDTH*PW-1:0] prs2;
    logic [WIDTH*PW-1:0] prd_old;
    logic                ckpt_req;
    logic                ckpt_gnt;
    logic [CW-1:0]       ckpt_id;
    logic                ckpt_free;
    logic                restore_en;
    logic [CW-1:0]       restore_id;
    logic [CW:0]         ckpt_cnt;
    logic                ckpt_full;
    logic                restore_err;

    rename_map_ckpt dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ren_vld     (ren_vld),
        .ren_we      (ren_we),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .prd_new     (prd_new),
        .prs1        (prs1),
        .prs2        (prs2),
        .prd_old     (prd_old),
        .ckpt_req    (ckpt_req),
        .ckpt_gnt    (ckpt_gnt),
        .ckpt_id     (ckpt_id),
        .ckpt_free   (ckpt_free),
        .restore_en  (restore_en),
        .restore_id  (restore_id),
        .ckpt_cnt    (ckpt_cnt),
        .ckpt_full   (ckpt_full),
        .restore_err (restore_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int vld, we;
        int rs1_0, rs2_0, rd_0, prd_0;
        int rs1_1, rs2_1, rd_1, prd_1;
        int req, free, ren, rid;
        int e_prs1_0, e_prs2_0, e_prs1_1, e_old_0, e_old_1;
        int e_gnt, e_id, e_cnt, e_full, e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: arch->phys map, snapshots by ID, live IDs oldest first
    int mmap [32];
    int snap_m [4][32];
    int live_q [$];
    int tail_m;
    int err_m;

    // Drive one cycle worth of inputs from a record
    task automatic apply_stimulus(input vec_t v);
        ren_vld    = 2'(v.vld);
        ren_we     = 2'(v.we);
        rs1        = {5'(v.rs1_1), 5'(v.rs1_0)};
        rs2        = {5'(v.rs2_1), 5'(v.rs2_0)};
        rd         = {5'(v.rd_1), 5'(v.rd_0)};
        prd_new    = {6'(v.prd_1), 6'(v.prd_0)};
        ckpt_req   = (v.req != 0);
        ckpt_free  = (v.free != 0);
        restore_en = (v.ren != 0);
        restore_id = 2'(v.rid);
    endtask

    // One comparison; logs a failure line on mismatch
    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    // Model: renamed value of arch register src as seen by way j
    function automatic int model_read(input vec_t v, input int j, input int src);
        int val;
        int rdv [2];
        int pv [2];
        rdv[0] = v.rd_0;  rdv[1] = v.rd_1;
        pv[0]  = v.prd_0; pv[1]  = v.prd_1;
        val = mmap[src];
        for (int k = 0; k < j; k++)
            if (((v.vld >> k) & 1) == 1 && ((v.we >> k) & 1) == 1 && rdv[k] == src)
                val = pv[k];
        return val;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mmap[i] = i;
        live_q.delete();
        tail_m = 0;
        err_m  = 0;
    endtask

    // Model: clock edge
    task automatic model_step(input vec_t v);
        int idx;
        int nmap [32];
        bit gnt_m;
        bit free_m;
        if (v.ren != 0) begin
            idx = -1;
            for (int i = 0; i < live_q.size(); i++)
                if (live_q[i] == v.rid) idx = i;
            if (idx >= 0) begin
                for (int i = 0; i < 32; i++) mmap[i] = snap_m[v.rid][i];
                while (live_q.size() > idx) void'(live_q.pop_back());
                tail_m = v.rid;
                err_m  = 0;
            end else begin
                err_m = 1;
            end
        end else begin
            err_m = 0;
            nmap = mmap;
            if ((v.vld & 1) == 1 && (v.we & 1) == 1) nmap[v.rd_0] = v.prd_0;
            if ((v.vld & 2) == 2 && (v.we & 2) == 2) nmap[v.rd_1] = v.prd_1;
            gnt_m  = (v.req != 0) && (live_q.size() < 4);
            free_m = (v.free != 0) && (live_q.size() > 0);
            if (gnt_m) begin
                for (int i = 0; i < 32; i++) snap_m[tail_m][i] = nmap[i];
                live_q.push_back(tail_m);
                tail_m = (tail_m + 1) % 4;
            end
            if (free_m) void'(live_q.pop_front());
            mmap = nmap;
        end
    endtask

    vec_t vecs [17];

    initial begin
        vec_t v;
        rst_n = 1'b0;
        apply_stimulus(idle_vec());

        //            vld we  w0:rs1 rs2 rd prd  w1:rs1 rs2 rd prd  req fr ren rid  prs1_0 prs2_0 prs1_1 old0 old1  gnt id cnt full err
        vecs[0]  = '{1, 0,  5, 31, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,   5, 31,  0,  0,  0,  0, 0, 0, 0, 0};
        vecs[1]  = '{3, 3,  1,  2, 3, 40,   3, 3, 3, 41,   0, 0, 0, 0,   1,  2, 40,  3, 40,  0, 0, 0, 0, 0};
        vecs[2]  = '{3, 1,  3,  0, 7, 50,   7, 3, 3,  0,   1, 0, 0, 0,  41,  0, 50,  7, 41,  1, 0, 0, 0, 0};
        vecs[3]  = '{1, 1,  7,  3, 7, 51,   0, 0, 0,  0,   1, 0, 1, 0,  50, 41,  0, 50,  0,  0, 1, 1, 0, 0};
        vecs[4]  = '{1, 0,  7,  3, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,  50, 41,  0,  0,  0,  0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 0, 0, 0,   0,  0,  0,  0,  0,  1, 0, 0, 0, 0};
        vecs[6]  = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 0, 0, 0,   0,  0,  0,  0,  0,  1, 1, 1, 0, 0};
        vecs[7]  = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 0, 0, 0,   0,  0,  0,  0,  0,  1, 2, 2, 0, 0};
        vecs[8]  = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 0, 0, 0,   0,  0,  0,  0,  0,  1, 3, 3, 0, 0};
        vecs[9]  = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 0, 0, 0,   0,  0,  0,  0,  0,  0, 0, 4, 1, 0};
        vecs[10] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 1, 0, 0,   0,  0,  0,  0,  0,  0, 0, 4, 1, 0};
        vecs[11] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 0, 3, 0, 0};
        vecs[12] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   0, 0, 1, 0,   0,  0,  0,  0,  0,  0, 0, 3, 0, 0};
        vecs[13] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 0, 3, 0, 1};
        vecs[14] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 0, 3, 0, 0};
        vecs[15] = '{0, 0,  0,  0, 0,  0,   0, 0, 0,  0,   1, 1, 1, 2,   0,  0,  0,  0,  0,  0, 0, 3, 0, 0};
        vecs[16] = '{1, 0,  7,  3, 0,  0,   0, 0, 0,  0,   0, 0, 0, 0,  50, 41,  0,  0,  0,  0, 2, 1, 0, 0};

        #12;
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int n = 0; n < 17; n++) begin
            apply_stimulus(vecs[n]);
            #1;
            check_output($sformatf("v%0d prs1_0", n), int'(prs1[0 +: PW]), vecs[n].e_prs1_0);
            check_output($sformatf("v%0d prs2_0", n), int'(prs2[0 +: PW]), vecs[n].e_prs2_0);
            check_output($sformatf("v%0d prs1_1", n), int'(prs1[PW +: PW]), vecs[n].e_prs1_1);
            check_output($sformatf("v%0d prd_old_0", n), int'(prd_old[0 +: PW]), vecs[n].e_old_0);
            check_output($sformatf("v%0d prd_old_1", n), int'(prd_old[PW +: PW]), vecs[n].e_old_1);
            check_output($sformatf("v%0d ckpt_gnt", n), int'(ckpt_gnt), vecs[n].e_gnt);
            check_output($sformatf("v%0d ckpt_id", n), int'(ckpt_id), vecs[n].e_id);
            check_output($sformatf("v%0d ckpt_cnt", n), int'(ckpt_cnt), vecs[n].e_cnt);
            check_output($sformatf("v%0d ckpt_full", n), int'(ckpt_full), vecs[n].e_full);
            check_output($sformatf("v%0d restore_err", n), int'(restore_err), vecs[n].e_err);
            tick();
        end

        $display("[TB] asynchronous reset with live checkpoints");
        v = idle_vec();
        v.req = 1;
        apply_stimulus(v);
        #1;
        check_output("pre-reset gnt", int'(ckpt_gnt), 1);
        check_output("pre-reset id", int'(ckpt_id), 2);
        tick();
        check_output("pre-reset cnt", int'(ckpt_cnt), 2);
        v = idle_vec();
        v.vld = 3; v.we = 1; v.rs1_0 = 3; v.rd_0 = 9; v.prd_0 = 33; v.rs1_1 = 7;
        apply_stimulus(v);
        #1;
        check_output("pre-reset prs1_0", int'(prs1[0 +: PW]), 41);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset cnt", int'(ckpt_cnt), 0);
        check_output("async reset full", int'(ckpt_full), 0);
        check_output("async reset prs1_0", int'(prs1[0 +: PW]), 3);
        check_output("async reset prs1_1", int'(prs1[PW +: PW]), 7);
        check_output("async reset id", int'(ckpt_id), 0);
        apply_stimulus(idle_vec());
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] pointer wrap and restore across the wrap");
        for (int k = 0; k < 3; k++) begin
            v = idle_vec();
            v.req = 1;
            apply_stimulus(v);
            #1;
            check_output($sformatf("wrap alloc%0d id", k), int'(ckpt_id), k);
            check_output($sformatf("wrap alloc%0d gnt", k), int'(ckpt_gnt), 1);
            tick();
        end
        check_output("wrap cnt after 3 alloc", int'(ckpt_cnt), 3);
        for (int k = 0; k < 3; k++) begin
            v = idle_vec();
            v.free = 1;
            apply_stimulus(v);
            tick();
        end
        check_output("wrap cnt after 3 free", int'(ckpt_cnt), 0);
        for (int k = 0; k < 2; k++) begin
            v = idle_vec();
            v.req = 1;
            apply_stimulus(v);
            #1;
            check_output($sformatf("wrap realloc%0d id", k), int'(ckpt_id), (3 + k) % 4);
            tick();
        end
        check_output("wrap cnt after realloc", int'(ckpt_cnt), 2);
        v = idle_vec();
        v.ren = 1; v.rid = 3; v.req = 1;
        apply_stimulus(v);
        #1;
        check_output("restore3 gnt denied", int'(ckpt_gnt), 0);
        tick();
        apply_stimulus(idle_vec());
        #1;
        check_output("restore3 cnt", int'(ckpt_cnt), 0);
        check_output("restore3 tail", int'(ckpt_id), 3);
        check_output("restore3 err", int'(restore_err), 0);
        v = idle_vec();
        v.ren = 1; v.rid = 1;
        apply_stimulus(v);
        tick();
        apply_stimulus(idle_vec());
        #1;
        check_output("bad restore err pulse", int'(restore_err), 1);
        check_output("bad restore cnt", int'(ckpt_cnt), 0);
        check_output("bad restore tail", int'(ckpt_id), 3);
        tick();
        check_output("bad restore err cleared", int'(restore_err), 0);

        $display("[TB] randomized run against reference model");
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            v = idle_vec();
            v.vld   = int'($urandom_range(0, 3));
            v.we    = int'($urandom_range(0, 3));
            v.rs1_0 = int'($urandom_range(0, 31));
            v.rs2_0 = int'($urandom_range(0, 31));
            v.rd_0  = int'($urandom_range(0, 7));
            v.prd_0 = int'($urandom_range(0, 63));
            v.rs1_1 = int'($urandom_range(0, 7));
            v.rs2_1 = int'($urandom_range(0, 31));
            v.rd_1  = int'($urandom_range(0, 7));
            v.prd_1 = int'($urandom_range(0, 63));
            v.req   = int'($urandom_range(0, 1));
            v.free  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            v.ren   = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v.rid   = int'($urandom_range(0, 3));
            apply_stimulus(v);
            #1;
            check_output("rnd prs1_0", int'(prs1[0 +: PW]), model_read(v, 0, v.rs1_0));
            check_output("rnd prs2_0", int'(prs2[0 +: PW]), model_read(v, 0, v.rs2_0));
            check_output("rnd prd_old_0", int'(prd_old[0 +: PW]), model_read(v, 0, v.rd_0));
            check_output("rnd prs1_1", int'(prs1[PW +: PW]), model_read(v, 1, v.rs1_1));
            check_output("rnd prs2_1", int'(prs2[PW +: PW]), model_read(v, 1, v.rs2_1));
            check_output("rnd prd_old_1", int'(prd_old[PW +: PW]), model_read(v, 1, v.rd_1));
            check_output("rnd ckpt_gnt", int'(ckpt_gnt),
                         (v.req != 0 && v.ren == 0 && live_q.size() < 4) ? 1 : 0);
            check_output("rnd ckpt_id", int'(ckpt_id), tail_m);
            check_output("rnd ckpt_cnt", int'(ckpt_cnt), live_q.size());
            check_output("rnd ckpt_full", int'(ckpt_full), (live_q.size() == 4) ? 1 : 0);
            check_output("rnd restore_err", int'(restore_err), err_m);
            model_step(v);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
